// File: rtl/ime_pkg.sv
// Shared definitions for the IME final stage: default widths and the
// per-frame payload that travels through the two pipeline stages.
package ime_pkg;

  localparam int W_ACC_DEF = 32;
  localparam int W_OUT_DEF = 16;
  localparam int W_SHIFT   = 5;

  // Everything a frame needs after acceptance. The configuration that was
  // live at acceptance rides along so later register writes cannot affect
  // frames already in the pipe.
  typedef struct packed {
    logic [W_ACC_DEF-1:0] value;
    logic [7:0]           tuser;
    logic                 last;
    logic                 poison;
    logic                 drop;
    logic [W_SHIFT-1:0]   cfg_shift;
  } ime_payload_t;

endpackage

// File: rtl/ime_round_sat.sv
// Combinational round-half-up right shift followed by unsigned saturation
// to the output sample width.
module ime_round_sat
  import ime_pkg::*;
#(
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic [W_ACC-1:0]   acc_i,
  input  logic [W_SHIFT-1:0] shift_i,
  output logic [W_OUT-1:0]   data_o,
  output logic               sat_o
);

  logic [W_ACC:0] half;
  logic [W_ACC:0] sum;
  logic [W_ACC:0] shifted;

  // One extra bit of headroom keeps acc + half from wrapping.
  always_comb begin
    half = '0;
    if (shift_i != '0) begin
      half = (W_ACC + 1)'(1) << (shift_i - W_SHIFT'(1));
    end
    sum     = {1'b0, acc_i} + half;
    shifted = sum >> shift_i;
    sat_o   = |shifted[W_ACC:W_OUT];
    data_o  = sat_o ? {W_OUT{1'b1}} : shifted[W_OUT-1:0];
  end

endmodule

// File: rtl/ime_final_stage.sv
// Final IME stage: two-stage valid/ready pipeline that rounds, shifts and
// saturates frame accumulations, optionally drops poisoned frames, and keeps
// saturating status counters.
module ime_final_stage
  import ime_pkg::*;
#(
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_ACC-1:0]   in_frame_acc,
  input  logic [7:0]         in_tuser,
  input  logic               in_last,
  input  logic               in_poison,
  input  logic [W_SHIFT-1:0] cfg_shift,
  input  logic               cfg_drop_poison,
  input  logic               cnt_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_OUT-1:0]   out_data,
  output logic [7:0]         out_tuser,
  output logic               out_last,
  output logic               out_poison,
  output logic               out_sat,
  output logic [31:0]        frame_count,
  output logic [15:0]        drop_count,
  output logic [15:0]        sat_count
);

  // Stage 1: captured frame plus its sampled configuration.
  ime_payload_t s1_q, s1_d;
  logic         s1_valid_q, s1_valid_d;

  // Stage 2: the presented output registers.
  logic             s2_valid_q, s2_valid_d;
  logic [W_OUT-1:0] out_data_q, out_data_d;
  logic [7:0]       out_tuser_q, out_tuser_d;
  logic             out_last_q, out_last_d;
  logic             out_poison_q, out_poison_d;
  logic             out_sat_q, out_sat_d;

  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] sat_count_q, sat_count_d;

  logic             s2_ready;
  logic             s1_adv;
  logic             accept;
  logic             emit;
  logic [W_OUT-1:0] rs_data;
  logic             rs_sat;

  // S2 can take a new frame when empty or when its frame leaves this cycle;
  // S1 refills whenever it is empty or moving into S2.
  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = s2_valid_q && out_ready;

  ime_round_sat #(
    .W_ACC (W_ACC),
    .W_OUT (W_OUT)
  ) u_round_sat (
    .acc_i   (s1_q.value),
    .shift_i (s1_q.cfg_shift),
    .data_o  (rs_data),
    .sat_o   (rs_sat)
  );

  // Pipeline next state: load S1 from the input, move S1 into S2; a dropped
  // frame simply leaves S2 empty for its own slot.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    s2_valid_d   = s2_valid_q;
    out_data_d   = out_data_q;
    out_tuser_d  = out_tuser_q;
    out_last_d   = out_last_q;
    out_poison_d = out_poison_q;
    out_sat_d    = out_sat_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.value     = in_frame_acc;
        s1_d.tuser     = in_tuser;
        s1_d.last      = in_last;
        s1_d.poison    = in_poison;
        s1_d.drop      = in_poison && cfg_drop_poison;
        s1_d.cfg_shift = cfg_shift;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q && !s1_q.drop;
      if (s1_valid_q && !s1_q.drop) begin
        out_data_d   = s1_q.poison ? '0 : rs_data;
        out_sat_d    = !s1_q.poison && rs_sat;
        out_tuser_d  = s1_q.tuser;
        out_last_d   = s1_q.last;
        out_poison_d = s1_q.poison;
      end
    end
  end

  // Status counters: saturate at all-ones, clear has priority over counting.
  always_comb begin
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    sat_count_d   = sat_count_q;
    if (cnt_clr) begin
      frame_count_d = '0;
      drop_count_d  = '0;
      sat_count_d   = '0;
    end else begin
      if (accept && (frame_count_q != '1)) frame_count_d = frame_count_q + 32'd1;
      if (s1_adv && s1_q.drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 16'd1;
      if (emit && out_sat_q && (sat_count_q != '1)) sat_count_d = sat_count_q + 16'd1;
    end
  end

  // State registers; reset empties the pipe and zeroes every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      s2_valid_q    <= 1'b0;
      out_data_q    <= '0;
      out_tuser_q   <= '0;
      out_last_q    <= 1'b0;
      out_poison_q  <= 1'b0;
      out_sat_q     <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      sat_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      s2_valid_q    <= s2_valid_d;
      out_data_q    <= out_data_d;
      out_tuser_q   <= out_tuser_d;
      out_last_q    <= out_last_d;
      out_poison_q  <= out_poison_d;
      out_sat_q     <= out_sat_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      sat_count_q   <= sat_count_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = out_data_q;
  assign out_tuser   = out_tuser_q;
  assign out_last    = out_last_q;
  assign out_poison  = out_poison_q;
  assign out_sat     = out_sat_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign sat_count   = sat_count_q;

endmodule

// File: tb/tb_ime_final_stage.sv
// Self-checking bench for ime_final_stage: directed scenarios plus a
// randomized run, all outputs scored against an arithmetic reference model.
module tb_ime_final_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_frame_acc = '0;
  logic [7:0]  in_tuser = '0;
  logic        in_last = 1'b0;
  logic        in_poison = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_drop_poison = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [7:0]  out_tuser;
  logic        out_last;
  logic        out_poison;
  logic        out_sat;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic [15:0] sat_count;

  // Output item packing: {data[15:0], tuser[7:0], last, poison, sat}
  typedef logic [26:0] item_t;
  item_t exp_q[$];
  item_t obs_q[$];

  int frame_m = 0, drop_m = 0, sat_m = 0;
  int acc_total = 0, emit_total = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ime_final_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_frame_acc    (in_frame_acc),
    .in_tuser        (in_tuser),
    .in_last         (in_last),
    .in_poison       (in_poison),
    .cfg_shift       (cfg_shift),
    .cfg_drop_poison (cfg_drop_poison),
    .cnt_clr         (cnt_clr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_tuser       (out_tuser),
    .out_last        (out_last),
    .out_poison      (out_poison),
    .out_sat         (out_sat),
    .frame_count     (frame_count),
    .drop_count      (drop_count),
    .sat_count       (sat_count)
  );

  // Reference: divide by 2^shift after adding half of it, clamp to 16 bits.
  function automatic item_t model(input logic [31:0] acc, input logic [4:0] sh,
                                  input logic [7:0] tu, input logic la, input logic po);
    longint unsigned pw, r;
    logic [15:0] d;
    logic s;
    pw = 64'd1 << sh;
    r  = (longint'(acc) + pw / 2) / pw;
    if (po) begin
      d = 16'd0; s = 1'b0;
    end else if (r > 64'd65535) begin
      d = 16'hFFFF; s = 1'b1;
    end else begin
      d = r[15:0]; s = 1'b0;
    end
    return {d, tu, la, po, s};
  endfunction

  // Watch both handshakes mid-cycle; predict outputs and counter values.
  always @(negedge clk) begin : mon
    int nf, nd, ns;
    item_t it;
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
      frame_m <= 0;
      drop_m  <= 0;
      sat_m   <= 0;
    end else begin
      nf = cnt_clr ? 0 : frame_m;
      nd = cnt_clr ? 0 : drop_m;
      ns = cnt_clr ? 0 : sat_m;
      if (in_valid && in_ready) begin
        acc_total <= acc_total + 1;
        if (!cnt_clr) nf = nf + 1;
        if (in_poison && cfg_drop_poison) begin
          nd = nd + 1;
        end else begin
          it = model(in_frame_acc, cfg_shift, in_tuser, in_last, in_poison);
          exp_q.push_back(it);
          if (it[0]) ns = ns + 1;
        end
      end
      if (out_valid && out_ready) begin
        emit_total <= emit_total + 1;
        obs_q.push_back({out_data, out_tuser, out_last, out_poison, out_sat});
      end
      frame_m <= nf;
      drop_m  <= nd;
      sat_m   <= ns;
    end
  end

  // Present one frame (caller is just after a posedge) and hold it until taken.
  task automatic send(input logic [31:0] acc, input logic [4:0] sh, input logic dp,
                      input logic po, input logic [7:0] tu, input logic la);
    int n = 0;
    in_valid = 1'b1; in_frame_acc = acc; cfg_shift = sh; cfg_drop_poison = dp;
    in_poison = po; in_tuser = tu; in_last = la;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_data, out_tuser, out_last, out_poison, out_sat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {out_valid, out_data, out_tuser, out_last, out_poison, out_sat});
    end
    checks++;
    if ({frame_count, drop_count, sat_count} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %h/%h/%h, required 0", frame_count, drop_count, sat_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_frame_acc = 32'h0001_2345; cfg_shift = 5'd4;
    cfg_drop_poison = 1'b0; in_poison = 1'b0; in_tuser = 8'h5A; in_last = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency1: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_sat, out_tuser, out_last} !== {1'b1, 16'h1234, 1'b0, 8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL basic_latency2: valid=%b data=%h sat=%b tuser=%h last=%b, required 1/1234/0/5a/1",
               out_valid, out_data, out_sat, out_tuser, out_last);
    end
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL basic_item: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturate();
    pulse_clr();
    send(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 8'h11, 1'b0);
    wait_drain();
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL sat_count_out: got %0d outputs, required 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL sat_item: got %h, required %h", o, e); end
    end
    checks++;
    if (sat_count !== 16'd1 || frame_count !== 32'(frame_m)) begin
      errors++;
      $display("FAIL sat_counters: sat_count=%0d frame_count=%0d, required 1/%0d", sat_count, frame_count, frame_m);
    end
  endtask

  task automatic test_poison();
    for (int mode = 1; mode >= 0; mode--) begin
      pulse_clr();
      send(32'h0000_0100, 5'd2, mode[0], 1'b0, 8'h01, 1'b0);
      send(32'h0000_0200, 5'd2, mode[0], 1'b1, 8'h02, 1'b0);
      send(32'h0000_0300, 5'd2, mode[0], 1'b0, 8'h03, 1'b1);
      wait_drain();
      checks++;
      if (obs_q.size() != (mode == 1 ? 2 : 3) || obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL poison_count_m%0d: got %0d outputs, required %0d", mode, obs_q.size(), mode == 1 ? 2 : 3);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        item_t e = exp_q.pop_front();
        item_t o = obs_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL poison_item_m%0d: got %h, required %h", mode, o, e); end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (drop_count !== 16'(mode) || frame_count !== 32'd3) begin
        errors++;
        $display("FAIL poison_counters_m%0d: drop=%0d frame=%0d, required %0d/3", mode, drop_count, frame_count, mode);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit saw_block;
    int buffered;
    bit have_prev;
    logic [27:0] prev, cur;
    base = acc_total - emit_total;
    saw_block = 0; buffered = -1; have_prev = 0; prev = '0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 8'(i), i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          cur = {out_valid, out_data, out_tuser, out_last, out_poison, out_sat};
          if (have_prev) begin
            checks++;
            if (cur !== prev) begin
              errors++; $display("FAIL stall_stable: got %h, required held %h", cur, prev);
            end
          end
          have_prev = out_valid && !out_ready;
          prev = cur;
          if (!in_ready && !saw_block) begin
            saw_block = 1;
            buffered = acc_total - emit_total - base;
          end
        end
      end
    join
    checks++;
    if (!saw_block || buffered != 2) begin
      errors++;
      $display("FAIL b2b_in_ready: blocked=%0d buffered=%0d, required 1/2", saw_block, buffered);
    end
    wait_drain();
    checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required 8", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_item: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    int bad;
    out_ready = 1'b1;
    send(32'h0000_1000, 5'd3, 1'b0, 1'b0, 8'hA0, 1'b0);
    send(32'h0000_2000, 5'd3, 1'b0, 1'b0, 8'hA1, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: out_valid=%b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sat, out_poison} !== '0 || {frame_count, drop_count, sat_count} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_now: valid=%b data=%h frame=%0d in_ready=%b, required 0/0/0/1",
               out_valid, out_data, frame_count, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL midrst_ghost: %0d cycles with out_valid, %0d outputs, required 0/0", bad, obs_q.size());
    end
    @(posedge clk); #1;
    send(32'h0000_0040, 5'd1, 1'b0, 1'b0, 8'hA2, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_item: got %h, required %h", o, e); end
    end
    checks++;
    if (frame_count !== 32'd1 || exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL midrst_after: frame_count=%0d, required 1", frame_count);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cnt_clr();
    send(32'h0000_0500, 5'd4, 1'b0, 1'b0, 8'hC0, 1'b0);
    wait_drain();
    in_valid = 1'b1; in_frame_acc = 32'h0000_0100; cfg_shift = 5'd4; cfg_drop_poison = 1'b0;
    in_poison = 1'b0; in_tuser = 8'hC1; in_last = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || frame_count === 32'd0) begin
      errors++; $display("FAIL clr_pre: in_ready=%b frame_count=%0d, required 1/nonzero", in_ready, frame_count);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clr = 1'b0;
    checks++;
    if (frame_count !== 32'd0) begin
      errors++; $display("FAIL clr_wins: frame_count=%0d, required 0", frame_count);
    end
    send(32'h0000_0200, 5'd4, 1'b0, 1'b0, 8'hC2, 1'b1);
    wait_drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL clr_item: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (frame_count !== 32'd1 || drop_count !== 16'd0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_after: frame=%0d drop=%0d sat=%0d, required 1/0/0", frame_count, drop_count, sat_count);
    end
  endtask

  task automatic test_random();
    bit done;
    logic [31:0] acc;
    done = 0;
    pulse_clr();
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          case ($urandom_range(0, 4))
            0: acc = 32'h0;
            1: acc = 32'hFFFF_FFFF;
            2: acc = 32'($urandom_range(0, 70000));
            default: acc = $urandom;
          endcase
          send(acc, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      item_t e = exp_q.pop_front();
      item_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rand_item: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (frame_count !== 32'(frame_m) || drop_count !== 16'(drop_m) || sat_count !== 16'(sat_m)) begin
      errors++;
      $display("FAIL rand_counters: got %0d/%0d/%0d, required %0d/%0d/%0d",
               frame_count, drop_count, sat_count, frame_m, drop_m, sat_m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_poison();
    test_back_to_back();
    test_cnt_clr();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
